// File: rtl/seg7_rx.sv
// rtl/seg7_rx.sv - seven-segment scan bus receiver and glyph decoder
module seg7_rx #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  seg,
  input  logic [7:0]  an,
  output logic [31:0] data,
  output logic [63:0] pixels,
  output logic [7:0]  valid,
  output logic [7:0]  bad,
  output logic        frame_done,
  output logic        an_err
);

  localparam logic [3:0] LAST  = 4'(SETTLE - 1);
  localparam logic [3:0] LIMIT = 4'(SETTLE);

  // {an, seg}; all-ones is the blank/idle bus
  logic [15:0] s1, s2, h;
  logic [3:0]  cnt;
  logic [7:0]  seen;

  logic        capture;
  logic [7:0]  an_low;
  logic        one_hot;
  logic [2:0]  idx;
  logic [4:0]  glyph;
  logic [7:0]  pix_new;
  logic [7:0]  seen_next;
  logic [5:0]  pix_base;
  logic [4:0]  nib_base;

  // Hex glyph lookup: {match, value}; DP is not part of the pattern
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F:   decode = {1'b1, 4'h0};
      7'h06:   decode = {1'b1, 4'h1};
      7'h5B:   decode = {1'b1, 4'h2};
      7'h4F:   decode = {1'b1, 4'h3};
      7'h66:   decode = {1'b1, 4'h4};
      7'h6D:   decode = {1'b1, 4'h5};
      7'h7D:   decode = {1'b1, 4'h6};
      7'h07:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h6F:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h7C:   decode = {1'b1, 4'hB};
      7'h58:   decode = {1'b1, 4'hC};
      7'h5E:   decode = {1'b1, 4'hD};
      7'h79:   decode = {1'b1, 4'hE};
      7'h71:   decode = {1'b1, 4'hF};
      default: decode = 5'h00;
    endcase
  endfunction

  // Capture fires once, on the cycle the settled count is reached
  assign capture = (s2 == h) && (cnt == LAST);

  // Digit select, glyph decode and frame bookkeeping for the held bus value
  always_comb begin
    an_low  = ~h[15:8];
    one_hot = (an_low != 8'h00) && ((an_low & (an_low - 8'd1)) == 8'h00);
    idx     = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (an_low[i]) idx = 3'(i);
    end
    glyph     = decode(~h[6:0]);
    pix_new   = ~h[7:0];
    seen_next = seen | (8'h01 << idx);
    // digit 0 sits in the top byte of the pixel image
    pix_base  = {~idx, 3'b000};
    nib_base  = {idx, 2'b00};
  end

  // Two-flop synchronizer on the raw bus
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 16'hFFFF;
      s2 <= 16'hFFFF;
    end else begin
      s1 <= {an, seg};
      s2 <= s1;
    end
  end

  // Stability filter: restart on any change, count up to SETTLE and park
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h   <= 16'hFFFF;
      cnt <= 4'd0;
    end else if (s2 != h) begin
      h   <= s2;
      cnt <= 4'd0;
    end else if (cnt < LIMIT) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Capture: update the selected digit, or flag a multi-digit enable
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data       <= 32'h0;
      pixels     <= 64'h0;
      valid      <= 8'h00;
      bad        <= 8'h00;
      seen       <= 8'h00;
      frame_done <= 1'b0;
      an_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      an_err     <= 1'b0;
      if (capture) begin
        if (one_hot) begin
          pixels[pix_base +: 8] <= pix_new;
          if (glyph[4]) begin
            data[nib_base +: 4] <= glyph[3:0];
            valid[idx]          <= 1'b1;
            bad[idx]            <= 1'b0;
          end else begin
            bad[idx] <= 1'b1;
          end
          if (seen_next == 8'hFF) begin
            frame_done <= 1'b1;
            seen       <= 8'h00;
          end else begin
            seen <= seen_next;
          end
        end else if (an_low != 8'h00) begin
          an_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_rx.sv
// tb/tb_seg7_rx.sv - scoreboard bench for seg7_rx
module tb_seg7_rx;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  seg = 8'hFF;
  logic [7:0]  an = 8'hFF;
  logic [31:0] data;
  logic [63:0] pixels;
  logic [7:0]  valid;
  logic [7:0]  bad;
  logic        frame_done;
  logic        an_err;

  seg7_rx #(.SETTLE(4)) dut (
    .clk(clk), .resetn(resetn), .seg(seg), .an(an),
    .data(data), .pixels(pixels), .valid(valid), .bad(bad),
    .frame_done(frame_done), .an_err(an_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [63:0] pix;
    logic [7:0]  valid;
    logic [7:0]  bad;
    logic        fd;
    logic        ae;
    int          cyc;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int passes = 0;

  logic [31:0] m_data;
  logic [63:0] m_pix;
  logic [7:0]  m_valid, m_bad, m_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  task automatic model_reset();
    m_data = 0; m_pix = 0; m_valid = 0; m_bad = 0; m_seen = 0;
  endtask

  // Monitor: any output change or pulse must match the next expected capture
  logic [111:0] prev = '0;
  logic [111:0] cur;
  exp_t e;
  always @(negedge clk) begin
    cur = {data, pixels, valid, bad};
    if (!resetn) begin
      prev = cur;
    end else if (cur !== prev || frame_done || an_err) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_update: cycle %0d data %h pixels %h valid %h bad %h fd %b ae %b",
                 cyc, data, pixels, valid, bad, frame_done, an_err);
      end else begin
        e = q.pop_front();
        chk("cap_cycle", 64'(cyc), 64'(e.cyc));
        chk("data", 64'(data), 64'(e.data));
        chk("pixels", pixels, e.pix);
        chk("valid", 64'(valid), 64'(e.valid));
        chk("bad", 64'(bad), 64'(e.bad));
        chk("frame_done", 64'(frame_done), 64'(e.fd));
        chk("an_err", 64'(an_err), 64'(e.ae));
      end
      prev = cur;
    end
  end

  task automatic gap(input int n);
    @(negedge clk);
    an = 8'hFF; seg = 8'hFF;
    repeat (n - 1) @(negedge clk);
  endtask

  // Show seg on digit d for hold cycles; nib/good are the hand-decoded result
  task automatic cap(input int d, input logic [7:0] s, input logic [3:0] nib,
                     input bit good, input int hold);
    exp_t x;
    @(negedge clk);
    an = ~(8'h01 << d); seg = s;
    if (hold >= 5) begin
      m_pix[(7 - d) * 8 +: 8] = ~s;
      if (good) begin
        m_data[4 * d +: 4] = nib;
        m_valid[d] = 1'b1;
        m_bad[d] = 1'b0;
      end else begin
        m_bad[d] = 1'b1;
      end
      m_seen[d] = 1'b1;
      x.fd = (m_seen == 8'hFF);
      if (x.fd) m_seen = 8'h00;
      x.data = m_data; x.pix = m_pix; x.valid = m_valid; x.bad = m_bad;
      x.ae = 1'b0; x.cyc = cyc + 7;
      q.push_back(x);
    end
    repeat (hold - 1) @(negedge clk);
  endtask

  task automatic multi_an(input logic [7:0] a, input logic [7:0] s, input int hold);
    exp_t x;
    @(negedge clk);
    an = a; seg = s;
    x.data = m_data; x.pix = m_pix; x.valid = m_valid; x.bad = m_bad;
    x.fd = 1'b0; x.ae = 1'b1; x.cyc = cyc + 7;
    q.push_back(x);
    repeat (hold - 1) @(negedge clk);
  endtask

  initial begin
    logic [15:0] r;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data", 64'(data), 64'h0);
    chk("rst_pixels", pixels, 64'h0);
    chk("rst_flags", 64'({valid, bad, frame_done, an_err}), 64'h0);
    @(negedge clk);
    resetn = 1'b1;
    gap(10);

    // single digit: 2 on digit 0, held 10 cycles
    cap(0, 8'hA4, 4'h2, 1'b1, 10);
    gap(2);

    // glitch rejection on digit 5: 4 cycles dropped, 5 cycles captured
    cap(5, 8'h82, 4'h6, 1'b1, 4);
    gap(2);
    cap(5, 8'h82, 4'h6, 1'b1, 5);
    gap(10);

    // full frame 0x1234ABCD, digit 0 = D ... digit 7 = 1
    cap(0, 8'hA1, 4'hD, 1'b1, 20); gap(2);
    cap(1, 8'hA7, 4'hC, 1'b1, 20); gap(2);
    cap(2, 8'h83, 4'hB, 1'b1, 20); gap(2);
    cap(3, 8'h88, 4'hA, 1'b1, 20); gap(2);
    cap(4, 8'h99, 4'h4, 1'b1, 20); gap(2);
    cap(5, 8'hB0, 4'h3, 1'b1, 20); gap(2);
    cap(6, 8'hA4, 4'h2, 1'b1, 20); gap(2);
    cap(7, 8'hF9, 4'h1, 1'b1, 20); gap(2);
    gap(10);
    chk("frame_data", 64'(data), 64'h1234ABCD);
    chk("frame_valid", 64'(valid), 64'hFF);
    chk("q_after_frame", 64'(q.size()), 64'h0);

    // reset mid-operation with a bus that changes every cycle
    r = 16'h5A3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      r = r ^ 16'(1 + $urandom_range(0, 16'hFFFE));
      an = r[15:8]; seg = r[7:0];
    end
    #2 resetn = 1'b0;
    #1;
    chk("midrst_data", 64'(data), 64'h0);
    chk("midrst_pixels", pixels, 64'h0);
    chk("midrst_flags", 64'({valid, bad, frame_done, an_err}), 64'h0);
    model_reset();
    gap(3);
    resetn = 1'b1;
    gap(12);

    // bad glyph on digit 3, then two digits enabled at once
    cap(3, 8'hB6, 4'h0, 1'b0, 10);
    gap(2);
    multi_an(8'hFC, 8'hA4, 10);
    gap(2);

    // DP with 0 on digit 0, then eight recaptures of digit 0
    cap(0, 8'h40, 4'h0, 1'b1, 10); gap(2);
    cap(0, 8'hF9, 4'h1, 1'b1, 10); gap(2);
    cap(0, 8'hA4, 4'h2, 1'b1, 10); gap(2);
    cap(0, 8'hB0, 4'h3, 1'b1, 10); gap(2);
    cap(0, 8'h99, 4'h4, 1'b1, 10); gap(2);
    cap(0, 8'h92, 4'h5, 1'b1, 10); gap(2);
    cap(0, 8'h82, 4'h6, 1'b1, 10); gap(2);
    cap(0, 8'hF8, 4'h7, 1'b1, 10); gap(2);
    cap(0, 8'h80, 4'h8, 1'b1, 10);
    gap(20);

    chk("final_bad", 64'(bad), 64'h08);
    chk("q_empty", 64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seg7_rx.md
# seg7_rx

Receive-side decoder for the multiplexed, active-low seven-segment bus (`seg[7:0]`, `an[7:0]`) driven by the display scanner. It samples the scanned bus, rejects transition glitches, and decodes each digit's segment pattern back into a hex nibble. It rebuilds the 32-bit displayed value and the 64-bit raw pixel image. It sits on the board-test and loopback path, where it checks display output without human inspection.

## Interface
- `SETTLE`, 4: sampled cycles a bus value must stay unchanged before capture; legal range 1..15.
- `clk`  in  1  system clock; all flops rise-edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `seg`  in  8  segment lines, active-low; bit0=A … bit6=G, bit7=DP.
- `an`  in  8  digit enables, active-low; bit i selects digit i.
- `data`  out  32  decoded value; digit i in `data[4i+3:4i]`.
- `pixels`  out  64  raw active-high patterns; digit i in `pixels[63-8i:56-8i]`.
- `valid`  out  8  bit i set once digit i has had a valid-glyph capture.
- `bad`  out  8  bit i set when the last capture of digit i was not a hex glyph.
- `frame_done`  out  1  one-cycle pulse when all 8 digits have been captured since the last pulse.
- `an_err`  out  1  one-cycle pulse on a capture with more than one `an` bit low.

## Operation
- **Input synchronizer.** Two-flop synchronizer on `{an,seg}` (s1, s2). Both stages reset to all-ones, which is the blank/idle bus.
- **Stability filter.** Hold register `h` (16 bits) and counter `cnt` (4 bits).
  - If s2 != h: load h<=s2 and cnt<=0.
  - Else if cnt<SETTLE: cnt<=cnt+1.
  - A capture fires on the edge where s2==h and cnt==SETTLE-1. It fires exactly once per stable period, and no capture fires while cnt==SETTLE.
- **Capture, h.an has exactly one low bit at position i:**
  - `pixels` slot i <= ~h.seg, all 8 bits including DP.
  - Decode p=~h.seg[6:0]. DP is ignored for decoding.
  - Glyph table:
    - 0=3F, 1=06, 2=5B, 3=4F
    - 4=66, 5=6D, 6=7D, 7=07
    - 8=7F, 9=6F, A=77, b=7C
    - c=58, d=5E, E=79, F=71
  - On a match: nibble i <= value, valid[i]<=1, bad[i]<=0.
  - On no match: bad[i]<=1; nibble i and valid[i] are unchanged.
  - seen[i]<=1 in both cases.
- **Capture, h.an all ones.** Blanking: no update, no error.
- **Capture, h.an with two or more low bits.** an_err<=1 for one cycle; no other state changes.
- **Frame tracking.** Internal `seen[7:0]`.
  - If the capture makes seen==8'hFF: frame_done<=1 for one cycle and seen<=0 on the same edge.
  - Recapturing a digit already seen does not pulse frame_done.
- **Reset values.** data=0, pixels=0, valid=0, bad=0, frame_done=0, an_err=0, seen=0, cnt=0, h=all-ones.
- **Reset mid-operation.** Asserting reset clears all state immediately and any partial frame is discarded. After release, a bus value still held is recaptured after the full latency below.

## Timing
- Bus value first present at edge k:
  - s1 at k, s2 at k+1.
  - h loaded and cnt=0 at k+2.
  - Capture edge k+2+SETTLE; outputs are visible after that edge.
  - With SETTLE=4, outputs update at edge k+6.
- Minimum bus hold for capture: SETTLE+1 clock cycles. Shorter values are dropped silently, including the intermediate codes seen while `an` and `seg` change skewed.
- frame_done and an_err are driven high from the capture edge and cleared on the next edge.
- Per digit, at most one capture and one output update per stable period.

## Test plan
- **Reset.** Pulse resetn low mid-cycle with random bus activity -> all outputs 0 immediately; no frame_done within 10 cycles of release while the bus is all-ones.
- **Single digit.** an=8'hFE, seg=8'hA4 held 10 cycles from edge k, SETTLE=4 -> at edge k+6: data[3:0]=2, pixels[63:56]=8'h5B, valid=8'h01, bad=0; no further update while held.
- **Full frame.** Scan 0x1234ABCD as digits 0..7, each held 20 cycles, with 2 all-ones cycles between digits -> data=32'h1234ABCD, valid=8'hFF, exactly one frame_done pulse on the digit-7 capture edge.
- **Glitch rejection.** Digit 5 value seg=8'h82 (6) held 4 cycles with SETTLE=4 -> no change to data/pixels/valid; the same value held 5 cycles -> data[23:20]=6.
- **Bad glyph and an error.** Digit 3 with ~seg=8'h49 -> bad[3]=1, data[15:12] unchanged, pixels[39:32]=8'h49. Then an=8'hFC held 10 cycles -> one an_err pulse and no state change.
- **DP and recapture.** Digit 0 with ~seg=8'hBF -> data[3:0]=0, pixels[63:56]=8'hBF. Recapture digit 0 with a valid glyph eight times -> no frame_done.
